// File: rtl/vga_rect_engine.sv
// vga_rect_engine: raster rectangle sweeper for the VGA pixel-plot port.
// Emits one (x, y, colour, plot) tuple per clock, with solid/checker/gradient/cycle fills.
module vga_rect_engine #(
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int CW     = 3,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int CHK    = 2
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [XW-1:0] rect_x,
  input  logic [YW-1:0] rect_y,
  input  logic [XW-1:0] rect_w,
  input  logic [YW-1:0] rect_h,
  input  logic [CW-1:0] color,
  output logic [XW-1:0] VGA_X,
  output logic [YW-1:0] VGA_Y,
  output logic [CW-1:0] VGA_COLOR,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_FIN
  } state_t;

  localparam logic [1:0]  M_CHK = 2'd1;
  localparam logic [1:0]  M_GRD = 2'd2;
  localparam logic [1:0]  M_CYC = 2'd3;
  localparam logic [XW:0] LIM_X = (XW+1)'(WIDTH);
  localparam logic [YW:0] LIM_Y = (YW+1)'(HEIGHT);

  state_t        r_state, w_state;
  logic [1:0]    r_mode, w_mode;
  logic [XW-1:0] r_x, w_x;
  logic [YW-1:0] r_y, w_y;
  logic [XW-1:0] r_w, w_w;
  logic [YW-1:0] r_h, w_h;
  logic [CW-1:0] r_col, w_col;
  logic [XW-1:0] r_xo, w_xo;
  logic [YW-1:0] r_yo, w_yo;
  logic [XW-1:0] r_vx, w_vx;
  logic [YW-1:0] r_vy, w_vy;
  logic [CW-1:0] r_vc, w_vc;
  logic          r_plot, w_plot;
  logic          r_busy, w_busy;
  logic          r_done, w_done;

  logic [XW:0]   w_px;
  logic [YW:0]   w_py;
  logic [CW-1:0] w_xo_lo;
  logic [CW-1:0] w_pc;
  logic          w_chk;
  logic          w_xlast;
  logic          w_ylast;

  assign w_px    = {1'b0, r_x} + {1'b0, r_xo};
  assign w_py    = {1'b0, r_y} + {1'b0, r_yo};
  assign w_xo_lo = CW'(r_xo);
  assign w_chk   = r_xo[CHK] ^ r_yo[CHK];
  assign w_xlast = (r_xo == r_w - XW'(1));
  assign w_ylast = (r_yo == r_h - YW'(1));

  assign VGA_X     = r_vx;
  assign VGA_Y     = r_vy;
  assign VGA_COLOR = r_vc;
  assign plot      = r_plot;
  assign busy      = r_busy;
  assign done      = r_done;

  // Fill colour of the pixel at the current raster offset.
  always_comb begin
    w_pc = r_col;
    unique case (r_mode)
      M_CHK:   w_pc = w_chk ? ~r_col : r_col;
      M_GRD:   w_pc = r_col + w_xo_lo;
      default: w_pc = r_col;
    endcase
  end

  // Next state, raster advance and next registered outputs.
  always_comb begin
    w_state = r_state;
    w_mode  = r_mode;
    w_x     = r_x;
    w_y     = r_y;
    w_w     = r_w;
    w_h     = r_h;
    w_col   = r_col;
    w_xo    = r_xo;
    w_yo    = r_yo;
    w_vx    = r_vx;
    w_vy    = r_vy;
    w_vc    = r_vc;
    w_plot  = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mode  = mode;
          w_x     = rect_x;
          w_y     = rect_y;
          w_w     = rect_w;
          w_h     = rect_h;
          w_col   = color;
          w_xo    = '0;
          w_yo    = '0;
          w_state = (rect_w == '0 || rect_h == '0) ? S_FIN : S_DRAW;
        end
      end
      S_DRAW: begin
        if (abort) begin
          w_state = S_IDLE;
        end else begin
          w_vx   = w_px[XW-1:0];
          w_vy   = w_py[YW-1:0];
          w_vc   = w_pc;
          w_plot = (w_px < LIM_X) && (w_py < LIM_Y);
          w_busy = 1'b1;
          if (!w_xlast) begin
            w_xo = r_xo + XW'(1);
          end else begin
            w_xo = '0;
            if (!w_ylast) begin
              w_yo = r_yo + YW'(1);
            end else if (r_mode == M_CYC) begin
              w_yo  = '0;
              w_col = r_col + CW'(1);
            end else begin
              w_state = S_FIN;
            end
          end
        end
      end
      S_FIN: begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_xo    <= '0;
      r_yo    <= '0;
      r_vx    <= '0;
      r_vy    <= '0;
      r_vc    <= '0;
      r_plot  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_mode  <= w_mode;
      r_x     <= w_x;
      r_y     <= w_y;
      r_w     <= w_w;
      r_h     <= w_h;
      r_col   <= w_col;
      r_xo    <= w_xo;
      r_yo    <= w_yo;
      r_vx    <= w_vx;
      r_vy    <= w_vy;
      r_vc    <= w_vc;
      r_plot  <= w_plot;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

endmodule

// File: tb/tb_vga_rect_engine.sv
// tb_vga_rect_engine: scoreboard bench for vga_rect_engine.
// Commands push expected per-cycle tuples; a monitor pops them as the DUT presents output.
module tb_vga_rect_engine;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [1:0] mode;
  logic [7:0] rect_x, rect_w, VGA_X;
  logic [6:0] rect_y, rect_h, VGA_Y;
  logic [2:0] color, VGA_COLOR;
  logic       plot, busy, done;

  always #5 clk = ~clk;

  vga_rect_engine dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .rect_x   (rect_x),
    .rect_y   (rect_y),
    .rect_w   (rect_w),
    .rect_h   (rect_h),
    .color    (color),
    .VGA_X    (VGA_X),
    .VGA_Y    (VGA_Y),
    .VGA_COLOR(VGA_COLOR),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int       cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    bit       pl;
    bit       dn;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every cycle the DUT shows activity, pop one expected tuple
  initial begin
    rec_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (busy || plot || done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected cyc=%0d busy=%b plot=%b done=%b x=%0d y=%0d",
                   cyc, busy, plot, done, VGA_X, VGA_Y);
        end else begin
          e = q.pop_front();
          if (e.dn)
            ok = (cyc == e.cyc) && done && !busy && !plot;
          else
            ok = (cyc == e.cyc) && !done && busy && (VGA_X == e.x) &&
                 (VGA_Y == e.y) && (VGA_COLOR == e.c) && (plot == e.pl);
          if (!ok) begin
            errors++;
            $display("FAIL pixel got cyc=%0d x=%0d y=%0d c=%0d plot=%b busy=%b done=%b want cyc=%0d x=%0d y=%0d c=%0d plot=%b done=%b",
                     cyc, VGA_X, VGA_Y, VGA_COLOR, plot, busy, done,
                     e.cyc, e.x, e.y, e.c, e.pl, e.dn);
          end
        end
      end
    end
  end

  task automatic check_zero(input string nm);
    checks++;
    if ({VGA_X, VGA_Y, VGA_COLOR, plot, busy, done} != '0) begin
      errors++;
      $display("FAIL %s got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b want all 0",
               nm, VGA_X, VGA_Y, VGA_COLOR, plot, busy, done);
    end
  endtask

  task automatic check_drained(input string nm);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s got %0d pending tuples want 0", nm, q.size());
    end
    q.delete();
  endtask

  // reference: pixel k of a sweep, from raster-order arithmetic
  function automatic rec_t model(input logic [1:0] m, input int x, input int y,
                                 input int w, input int h, input logic [2:0] c,
                                 input int k, input int s);
    rec_t r;
    int tot, kk, xo, yo, px, py;
    tot = w * h;
    kk  = k % tot;
    xo  = kk % w;
    yo  = kk / w;
    px  = x + xo;
    py  = y + yo;
    r.cyc = s + 2 + k;
    r.x   = 8'(px);
    r.y   = 7'(py);
    r.pl  = (px < 160) && (py < 120);
    r.dn  = 1'b0;
    case (m)
      2'd0: r.c = c;
      2'd1: r.c = ((((xo >> 2) ^ (yo >> 2)) & 1) != 0) ? ~c : c;
      2'd2: r.c = 3'(int'(c) + xo);
      default: r.c = 3'(int'(c) + k / tot);
    endcase
    return r;
  endfunction

  task automatic run(input logic [1:0] m, input logic [7:0] x, input logic [6:0] y,
                     input logic [7:0] w, input logic [6:0] h, input logic [2:0] c,
                     input int ab, input bit poke, input bit sa);
    int   s, tot, n;
    rec_t r;
    @(negedge clk);
    mode = m; rect_x = x; rect_y = y; rect_w = w; rect_h = h; color = c;
    start = 1'b1; abort = sa;
    s   = cyc;
    tot = int'(w) * int'(h);
    if (tot == 0)    n = 0;
    else if (ab > 0) n = ab;
    else             n = tot;
    for (int k = 0; k < n; k++) q.push_back(model(m, x, y, w, h, c, k, s));
    if (tot == 0 || ab <= 0) begin
      r = '{cyc: s + 2 + n, x: '0, y: '0, c: '0, pl: 1'b0, dn: 1'b1};
      q.push_back(r);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    mode = 2'($urandom); rect_x = 8'($urandom); rect_y = 7'($urandom);
    rect_w = 8'($urandom); rect_h = 7'($urandom); color = 3'($urandom);
    if (poke && ab <= 0 && tot >= 3) begin
      while (cyc < s + 3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (tot > 0 && ab > 0) begin
      while (cyc < s + 1 + ab) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy || plot || done) begin
        errors++;
        $display("FAIL abort got busy=%b plot=%b done=%b want 0 0 0", busy, plot, done);
      end
      repeat (3) @(negedge clk);
    end else begin
      while (cyc < s + 3 + n) @(negedge clk);
    end
    @(negedge clk);
    check_drained("drain");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s, tot, ab;
    logic [1:0] m;
    logic [7:0] w;
    logic [6:0] h;
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = '0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; color = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    run(2'd0, 8'd10,  7'd20,  8'd3, 7'd2, 3'd5, 0, 0, 0);
    run(2'd0, 8'd158, 7'd119, 8'd4, 7'd2, 3'd1, 0, 0, 0);
    run(2'd1, 8'd0,   7'd0,   8'd8, 7'd8, 3'd3, 0, 0, 0);
    run(2'd2, 8'd30,  7'd30,  8'd4, 7'd3, 3'd6, 0, 0, 0);
    run(2'd3, 8'd5,   7'd5,   8'd2, 7'd1, 3'd7, 9, 0, 0);
    run(2'd0, 8'd1,   7'd1,   8'd0, 7'd5, 3'd4, 0, 0, 0);
    run(2'd0, 8'd1,   7'd1,   8'd5, 7'd0, 3'd4, 0, 0, 0);
    run(2'd0, 8'd40,  7'd40,  8'd5, 7'd3, 3'd2, 0, 1, 0);
    run(2'd1, 8'd50,  7'd9,   8'd9, 7'd2, 3'd1, 0, 0, 1);
    run(2'd2, 8'd0,   7'd0,   8'd10, 7'd4, 3'd0, 7, 0, 0);

    for (int i = 0; i < 25; i++) begin
      m   = 2'($urandom_range(0, 3));
      w   = 8'($urandom_range(0, 12));
      h   = 7'($urandom_range(0, 6));
      tot = int'(w) * int'(h);
      if (m == 2'd3)
        ab = $urandom_range(1, 40);
      else if ($urandom_range(0, 3) == 0 && tot > 1)
        ab = $urandom_range(1, tot - 1);
      else
        ab = 0;
      run(m, 8'($urandom), 7'($urandom), w, h, 3'($urandom),
          ab, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    mode = 2'd0; rect_x = 8'd0; rect_y = 7'd0;
    rect_w = 8'd20; rect_h = 7'd5; color = 3'd2; start = 1'b1;
    s = cyc;
    for (int k = 0; k < 5; k++) q.push_back(model(2'd0, 0, 0, 20, 5, 3'd2, k, s));
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    check_zero("rst_hold");
    repeat (4) @(negedge clk);
    check_zero("rst_after");
    check_drained("rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
